// File: rtl/add_state_pipe.sv
// Mantissa add/subtract stage of the HCORDIC floating-point pipeline.
// Combinational sign-magnitude add feeding a two-entry (main + skid) output buffer.
module add_state_pipe #(
    parameter  int MANT_W = 27,
    parameter  int EXP_W  = 8,
    parameter  int BIAS   = 127,
    parameter  int FRAC_W = 23,
    parameter  int TAG_W  = 8,
    localparam int OP_W   = 1 + EXP_W + MANT_W,
    localparam int S_W    = 1 + EXP_W + FRAC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        idle_in,
    input  logic [OP_W-1:0]   c_in,
    input  logic [OP_W-1:0]   z_in,
    input  logic [S_W-1:0]    s_in,
    input  logic [1:0]        mode_in,
    input  logic              operation_in,
    input  logic              natlog_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        idle_out,
    output logic [1:0]        mode_out,
    output logic              operation_out,
    output logic              natlog_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic [S_W-1:0]    s_out,
    output logic [MANT_W:0]   sum_out,
    output logic              exp_mismatch
);

    localparam logic [1:0]       PUT_IDLE = 2'b10;
    localparam logic [EXP_W-1:0] BIAS_V   = EXP_W'(BIAS);

    typedef struct packed {
        logic [1:0]       idle;
        logic [1:0]       mode;
        logic             operation;
        logic             natlog;
        logic [TAG_W-1:0] tag;
        logic [S_W-1:0]   s;
        logic [MANT_W:0]  sum;
        logic             mismatch;
    } beat_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    logic              c_sign;
    logic              z_sign;
    logic [EXP_W-1:0]  c_exp;
    logic [EXP_W-1:0]  z_exp;
    logic [MANT_W-1:0] c_mant;
    logic [MANT_W-1:0] z_mant;
    logic [EXP_W-1:0]  exp_unbiased;
    logic              res_sign;
    logic [MANT_W:0]   res_sum;
    logic              accept;
    beat_t             new_beat;
    beat_t             main_q;
    beat_t             skid_q;
    occ_t              occ;

    assign c_sign       = c_in[OP_W-1];
    assign z_sign       = z_in[OP_W-1];
    assign c_exp        = c_in[OP_W-2 -: EXP_W];
    assign z_exp        = z_in[OP_W-2 -: EXP_W];
    assign c_mant       = c_in[MANT_W-1:0];
    assign z_mant       = z_in[MANT_W-1:0];
    assign exp_unbiased = c_exp - BIAS_V;
    assign accept       = in_valid && in_ready;

    // Sign-magnitude add: the larger magnitude decides the sign, and an exact zero is always positive.
    always_comb begin
        res_sum  = '0;
        res_sign = 1'b0;
        if (c_sign == z_sign) begin
            res_sum  = {1'b0, c_mant} + {1'b0, z_mant};
            res_sign = c_sign;
        end else if (c_mant >= z_mant) begin
            res_sum  = {1'b0, c_mant - z_mant};
            res_sign = c_sign;
        end else begin
            res_sum  = {1'b0, z_mant - c_mant};
            res_sign = z_sign;
        end
        if (res_sum == '0) begin
            res_sign = 1'b0;
        end
    end

    always_comb begin
        new_beat           = '0;
        new_beat.idle      = idle_in;
        new_beat.mode      = mode_in;
        new_beat.operation = operation_in;
        new_beat.natlog    = natlog_in;
        new_beat.tag       = tag_in;
        if (idle_in == PUT_IDLE) begin
            new_beat.s        = s_in;
            new_beat.sum      = '0;
            new_beat.mismatch = 1'b0;
        end else begin
            new_beat.s        = {res_sign, exp_unbiased, {FRAC_W{1'b0}}};
            new_beat.sum      = res_sum;
            new_beat.mismatch = (c_exp != z_exp);
        end
    end

    // Main register is what the consumer sees; skid catches one beat while main is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ       <= OCC_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        main_q    <= new_beat;
                        out_valid <= 1'b1;
                        occ       <= OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (out_ready) begin
                        if (accept) begin
                            main_q <= new_beat;
                        end else begin
                            out_valid <= 1'b0;
                            occ       <= OCC_EMPTY;
                        end
                    end else if (accept) begin
                        skid_q   <= new_beat;
                        in_ready <= 1'b0;
                        occ      <= OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (out_ready) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        occ      <= OCC_MAIN;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occ       <= OCC_EMPTY;
                end
            endcase
        end
    end

    assign idle_out      = main_q.idle;
    assign mode_out      = main_q.mode;
    assign operation_out = main_q.operation;
    assign natlog_out    = main_q.natlog;
    assign tag_out       = main_q.tag;
    assign s_out         = main_q.s;
    assign sum_out       = main_q.sum;
    assign exp_mismatch  = main_q.mismatch;

endmodule

// File: tb/tb_add_state_pipe.sv
// Self-checking bench for add_state_pipe: directed table, handshake sequences,
// and randomized traffic against a signed-arithmetic reference model.
module tb_add_state_pipe;

    localparam int MANT_W = 27;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;
    localparam int FRAC_W = 23;
    localparam int TAG_W  = 8;
    localparam int OP_W   = 1 + EXP_W + MANT_W;
    localparam int S_W    = 1 + EXP_W + FRAC_W;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        idle_in;
    logic [OP_W-1:0]   c_in;
    logic [OP_W-1:0]   z_in;
    logic [S_W-1:0]    s_in;
    logic [1:0]        mode_in;
    logic              operation_in;
    logic              natlog_in;
    logic [TAG_W-1:0]  tag_in;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        idle_out;
    logic [1:0]        mode_out;
    logic              operation_out;
    logic              natlog_out;
    logic [TAG_W-1:0]  tag_out;
    logic [S_W-1:0]    s_out;
    logic [MANT_W:0]   sum_out;
    logic              exp_mismatch;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [1:0]       idle;
        logic [1:0]       mode;
        logic             op;
        logic             nl;
        logic [TAG_W-1:0] tag;
        logic [S_W-1:0]   s;
        logic [MANT_W:0]  sum;
        logic             mm;
    } beat_t;

    typedef struct {
        logic [1:0]        idle;
        logic              cs;
        logic [EXP_W-1:0]  ce;
        logic [MANT_W-1:0] cm;
        logic              zs;
        logic [EXP_W-1:0]  ze;
        logic [MANT_W-1:0] zm;
        logic [S_W-1:0]    s;
        logic [1:0]        mode;
        logic              op;
        logic              nl;
        logic [TAG_W-1:0]  tag;
        logic [S_W-1:0]    s_exp;
        logic [MANT_W:0]   sum_exp;
        logic              mm_exp;
    } vec_t;

    vec_t  vecs[8];
    beat_t expq[$];

    add_state_pipe #(
        .MANT_W(MANT_W), .EXP_W(EXP_W), .BIAS(BIAS), .FRAC_W(FRAC_W), .TAG_W(TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .idle_in(idle_in), .c_in(c_in), .z_in(z_in), .s_in(s_in),
        .mode_in(mode_in), .operation_in(operation_in), .natlog_in(natlog_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .idle_out(idle_out), .mode_out(mode_out), .operation_out(operation_out),
        .natlog_out(natlog_out), .tag_out(tag_out),
        .s_out(s_out), .sum_out(sum_out), .exp_mismatch(exp_mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic beat_t dut_beat();
        return '{idle: idle_out, mode: mode_out, op: operation_out, nl: natlog_out,
                 tag: tag_out, s: s_out, sum: sum_out, mm: exp_mismatch};
    endfunction

    // Reference: treat each operand as a signed integer and take magnitude/sign of the true sum.
    function automatic beat_t model(input logic [1:0] idle, input logic cs, input logic [EXP_W-1:0] ce,
                                    input logic [MANT_W-1:0] cm, input logic zs, input logic [EXP_W-1:0] ze,
                                    input logic [MANT_W-1:0] zm, input logic [S_W-1:0] s,
                                    input logic [1:0] mode, input logic op, input logic nl,
                                    input logic [TAG_W-1:0] tag);
        beat_t  b;
        longint cv, zv, r;
        int     e;
        b.idle = idle; b.mode = mode; b.op = op; b.nl = nl; b.tag = tag;
        if (idle == 2'b10) begin
            b.s = s; b.sum = '0; b.mm = 1'b0;
        end else begin
            cv = cs ? -longint'(cm) : longint'(cm);
            zv = zs ? -longint'(zm) : longint'(zm);
            r  = cv + zv;
            e  = (int'(ce) - BIAS + 256) % 256;
            b.sum = (r < 0) ? (MANT_W+1)'(-r) : (MANT_W+1)'(r);
            b.s   = {(r < 0), e[EXP_W-1:0], {FRAC_W{1'b0}}};
            b.mm  = (ce != ze);
        end
        return b;
    endfunction

    task automatic drive(input logic v, input logic [1:0] idle, input logic cs, input logic [EXP_W-1:0] ce,
                         input logic [MANT_W-1:0] cm, input logic zs, input logic [EXP_W-1:0] ze,
                         input logic [MANT_W-1:0] zm, input logic [S_W-1:0] s, input logic [1:0] mode,
                         input logic op, input logic nl, input logic [TAG_W-1:0] tag);
        in_valid = v; idle_in = idle;
        c_in = {cs, ce, cm}; z_in = {zs, ze, zm}; s_in = s;
        mode_in = mode; operation_in = op; natlog_in = nl; tag_in = tag;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clock); #1;
        drive(1'b1, v.idle, v.cs, v.ce, v.cm, v.zs, v.ze, v.zm, v.s, v.mode, v.op, v.nl, v.tag);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string n;
        n = $sformatf("vec%0d", idx);
        check({n, "_valid"}, 128'(out_valid), 128'(1'b1));
        check({n, "_s"}, 128'(s_out), 128'(v.s_exp));
        check({n, "_sum"}, 128'(sum_out), 128'(v.sum_exp));
        check({n, "_mismatch"}, 128'(exp_mismatch), 128'(v.mm_exp));
        check({n, "_sideband"}, 128'({idle_out, mode_out, operation_out, natlog_out, tag_out}),
              128'({v.idle, v.mode, v.op, v.nl, v.tag}));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 128'(dut_beat()), 128'(0));
        check({name, "_valid"}, 128'(out_valid), 128'(1'b0));
        check({name, "_ready"}, 128'(in_ready), 128'(1'b0));
    endtask

    initial begin
        vecs[0] = '{2'b00, 0, 8'h80, 27'h4000000, 0, 8'h80, 27'h2000000, 32'h0, 2'b01, 0, 0, 8'hA1,
                    32'h00800000, 28'h6000000, 1'b0};
        vecs[1] = '{2'b00, 0, 8'h7F, 27'h1000000, 1, 8'h7E, 27'h3000000, 32'h0, 2'b00, 1, 0, 8'hA2,
                    32'h80000000, 28'h2000000, 1'b1};
        vecs[2] = '{2'b01, 1, 8'h81, 27'h5555555, 0, 8'h81, 27'h5555555, 32'h0, 2'b11, 0, 1, 8'hA3,
                    32'h01000000, 28'h0, 1'b0};
        vecs[3] = '{2'b10, 1, 8'h10, 27'h0000123, 0, 8'h20, 27'h0000456, 32'hDEADBEEF, 2'b01, 1, 1, 8'hA4,
                    32'hDEADBEEF, 28'h0, 1'b0};
        vecs[4] = '{2'b00, 1, 8'hFF, 27'h7FFFFFF, 1, 8'hFF, 27'h7FFFFFF, 32'h0, 2'b11, 1, 0, 8'hA5,
                    32'hC0000000, 28'hFFFFFFE, 1'b0};
        vecs[5] = '{2'b00, 0, 8'h00, 27'h0000001, 1, 8'h05, 27'h0000003, 32'h0, 2'b00, 0, 0, 8'hA6,
                    32'hC0800000, 28'h2, 1'b1};
        vecs[6] = '{2'b00, 1, 8'h7F, 27'h0, 1, 8'h7F, 27'h0, 32'h0, 2'b01, 0, 1, 8'hA7,
                    32'h00000000, 28'h0, 1'b0};
        vecs[7] = '{2'b00, 1, 8'h90, 27'h0000100, 0, 8'h90, 27'h0000001, 32'h0, 2'b00, 1, 1, 8'hA8,
                    32'h88800000, 28'hFF, 1'b0};

        reset = 1'b1; out_ready = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        check_all_zero("reset_state");
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_ready", 128'(in_ready), 128'(1'b1));
        check("post_reset_valid", 128'(out_valid), 128'(1'b0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        @(posedge clock); #1;
        check("drain_empty", 128'(out_valid), 128'(1'b0));

        // Backpressure: two beats buffered, third held off, released in order.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 0, 8'h80, 27'h1, 0, 8'h80, 27'h1, 0, 2'b01, 0, 0, 8'd1);
        @(posedge clock); #1;
        check("bp_tag1_valid", 128'({out_valid, tag_out, in_ready}), 128'({1'b1, 8'd1, 1'b1}));
        drive(1'b1, 2'b00, 0, 8'h80, 27'h2, 0, 8'h80, 27'h2, 0, 2'b01, 0, 0, 8'd2);
        @(posedge clock); #1;
        check("bp_ready_low", 128'(in_ready), 128'(1'b0));
        check("bp_hold1", 128'({out_valid, tag_out, sum_out}), 128'({1'b1, 8'd1, 28'd2}));
        drive(1'b1, 2'b00, 0, 8'h80, 27'h3, 0, 8'h80, 27'h3, 0, 2'b01, 0, 0, 8'd3);
        @(posedge clock); #1;
        check("bp_tag3_held", 128'(in_ready), 128'(1'b0));
        check("bp_hold2", 128'({out_valid, tag_out, sum_out}), 128'({1'b1, 8'd1, 28'd2}));
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_out_tag2", 128'({out_valid, tag_out, sum_out, in_ready}), 128'({1'b1, 8'd2, 28'd4, 1'b1}));
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bp_out_tag3", 128'({out_valid, tag_out, sum_out}), 128'({1'b1, 8'd3, 28'd6}));
        @(posedge clock); #1;
        check("bp_done", 128'(out_valid), 128'(1'b0));

        // Reset with two beats buffered.
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 1, 8'h90, 27'h7, 0, 8'h91, 27'h1, 32'h1234, 2'b11, 1, 1, 8'h11);
        @(posedge clock); #1;
        drive(1'b1, 2'b10, 1, 8'h90, 27'h7, 0, 8'h91, 27'h1, 32'h1234, 2'b11, 1, 1, 8'h22);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("rst_pre_full", 128'({out_valid, in_ready}), 128'({1'b1, 1'b0}));
        #2 reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clock); #3 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("rst_ready_after", 128'(in_ready), 128'(1'b1));
        begin
            bit stale = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (out_valid) stale = 1'b1;
                @(posedge clock); #1;
            end
            check("rst_no_stale", 128'(stale), 128'(1'b0));
        end

        // Randomized traffic against the reference model.
        begin
            bit    stalled = 1'b0;
            beat_t held;
            beat_t exp_b;
            for (int cyc = 0; cyc < 600; cyc++) begin
                logic [EXP_W-1:0]  ce, ze;
                logic [MANT_W-1:0] cm, zm;
                logic [1:0]        idle;
                @(negedge clock);
                if (stalled) begin
                    check("rnd_stall_hold", 128'({out_valid, dut_beat()}), 128'({1'b1, held}));
                end
                stalled = out_valid && !out_ready;
                held    = dut_beat();
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("rnd_unexpected_beat", 128'(dut_beat()), 128'(0));
                    end else begin
                        exp_b = expq.pop_front();
                        check($sformatf("rnd_beat_c%0d", cyc), 128'(dut_beat()), 128'(exp_b));
                    end
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model(idle_in, c_in[OP_W-1], c_in[OP_W-2 -: EXP_W], c_in[MANT_W-1:0],
                                         z_in[OP_W-1], z_in[OP_W-2 -: EXP_W], z_in[MANT_W-1:0], s_in,
                                         mode_in, operation_in, natlog_in, tag_in));
                end
                @(posedge clock); #1;
                ce   = EXP_W'($urandom);
                cm   = MANT_W'($urandom);
                ze   = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom) : ce;
                zm   = ($urandom_range(0, 4) == 0) ? cm : MANT_W'($urandom);
                idle = 2'($urandom_range(0, 3));
                drive(($urandom_range(0, 3) != 0), idle, 1'($urandom), ce, cm, 1'($urandom), ze, zm,
                      32'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), TAG_W'(cyc));
                out_ready = ($urandom_range(0, 2) != 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                if (out_valid) begin
                    if (expq.size() == 0) begin
                        check("drain_unexpected_beat", 128'(dut_beat()), 128'(0));
                    end else begin
                        exp_b = expq.pop_front();
                        check("drain_beat", 128'(dut_beat()), 128'(exp_b));
                    end
                end
            end
            check("drain_queue_empty", 128'(expq.size()), 128'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
